// File: rtl/sseg_arbiter.sv
// sseg_arbiter: round-robin owner selection for the shared four-digit
// seven-segment display word. Each grant is held for HOLD_CYCLES cycles,
// the owner's word is passed through with one cycle of latency, and the
// idle pattern is shown whenever nobody holds the display.
module sseg_arbiter #(
  parameter int          NREQ         = 4,
  parameter int          HOLD_CYCLES  = 16,
  parameter logic [15:0] IDLE_PATTERN = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [NREQ-1:0]         req,
  input  logic [16*NREQ-1:0]      req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [15:0]             display_data
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [OW-1:0]   PTR_INIT = OW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  cnt_r;
  logic [OW-1:0]  last_r;

  logic           found_s;
  logic [OW-1:0]  win_s;
  logic [OW-1:0]  idx_s;
  logic [15:0]    win_data_s;
  logic [15:0]    own_data_s;

  // Round-robin search starting just after the last winner; scanning from the
  // farthest position back to the nearest lets the nearest active request win.
  always_comb begin
    found_s = 1'b0;
    win_s   = last_r;
    idx_s   = last_r;
    for (int k = NREQ; k >= 1; k--) begin
      idx_s   = OW'((int'(last_r) + k) % NREQ);
      found_s = found_s | req[idx_s];
      win_s   = req[idx_s] ? idx_s : win_s;
    end
    win_data_s = req_data[16*int'(win_s) +: 16];
    own_data_s = req_data[16*int'(owner) +: 16];
  end

  // Arbitration FSM with hold counter; every output is a register of this block.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      last_r       <= PTR_INIT;
      owner        <= {OW{1'b0}};
      gnt          <= {NREQ{1'b0}};
      busy         <= 1'b0;
      display_data <= IDLE_PATTERN;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r      <= SHOW;
            cnt_r        <= {CW{1'b0}};
            last_r       <= win_s;
            owner        <= win_s;
            gnt          <= ONE_HOT0 << win_s;
            busy         <= 1'b1;
            display_data <= win_data_s;
          end else begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            gnt          <= {NREQ{1'b0}};
            busy         <= 1'b0;
            display_data <= IDLE_PATTERN;
          end
        end
        SHOW: begin
          if (cnt_r == CNT_LAST) begin
            if (found_s) begin
              // Back-to-back handover (or re-grant) without an idle gap.
              state_r      <= SHOW;
              cnt_r        <= {CW{1'b0}};
              last_r       <= win_s;
              owner        <= win_s;
              gnt          <= ONE_HOT0 << win_s;
              busy         <= 1'b1;
              display_data <= win_data_s;
            end else begin
              // Owner index is kept so software can see who held it last.
              state_r      <= IDLE;
              cnt_r        <= {CW{1'b0}};
              gnt          <= {NREQ{1'b0}};
              busy         <= 1'b0;
              display_data <= IDLE_PATTERN;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (req[owner]) begin
              display_data <= own_data_s;
            end else begin
              display_data <= display_data;
            end
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= {CW{1'b0}};
          last_r       <= PTR_INIT;
          owner        <= {OW{1'b0}};
          gnt          <= {NREQ{1'b0}};
          busy         <= 1'b0;
          display_data <= IDLE_PATTERN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_arbiter.sv
// tb_sseg_arbiter: directed scenarios plus randomized traffic. A reference
// model predicts the outputs after every clock edge and queues them; a monitor
// compares the DUT against the queue on every falling edge.
module tb_sseg_arbiter;

  localparam int          NREQ   = 4;
  localparam int          HOLD   = 4;
  localparam logic [15:0] IDLE_W = 16'hFFFF;

  logic        clk = 1'b0;
  logic        clear;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] display_data;

  sseg_arbiter #(
    .NREQ(NREQ),
    .HOLD_CYCLES(HOLD),
    .IDLE_PATTERN(IDLE_W)
  ) dut (
    .clk(clk),
    .clear(clear),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .owner(owner),
    .busy(busy),
    .display_data(display_data)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] disp;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] data[NREQ];
  int          checks = 0;
  int          passed = 0;

  // Reference model: who holds the display, how many hold cycles remain.
  bit          m_busy;
  int          m_owner;
  int          m_last;
  int          m_left;
  logic [15:0] m_disp;

  function automatic int rr_pick(logic [3:0] r, int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic void model_step(logic c, logic [3:0] r);
    int w;
    if (c) begin
      m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_left = 0; m_disp = IDLE_W;
    end else if (!m_busy || m_left == 1) begin
      w = rr_pick(r, m_last);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_last = w; m_left = HOLD; m_disp = data[w];
      end else begin
        m_busy = 0; m_left = 0; m_disp = IDLE_W;
      end
    end else begin
      m_left = m_left - 1;
      if (r[m_owner]) m_disp = data[m_owner];
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt   = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    e.owner = 2'(m_owner);
    e.busy  = m_busy;
    e.disp  = m_disp;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, expv, $time);
  endtask

  // Apply inputs, advance the model over the same edge, queue its prediction.
  task automatic step(input logic c, input logic [3:0] r);
    clear = c;
    req   = r;
    for (int i = 0; i < NREQ; i++) req_data[16*i +: 16] = data[i];
    model_step(c, r);
    @(posedge clk);
    exp_q.push_back(model_out());
    #2;
  endtask

  // Monitor: compare each registered output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_gnt",   32'(gnt),          32'(e.gnt));
        chk("sb_owner", 32'(owner),        32'(e.owner));
        chk("sb_busy",  32'(busy),         32'(e.busy));
        chk("sb_disp",  32'(display_data), 32'(e.disp));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rq;
    for (int i = 0; i < NREQ; i++) data[i] = 16'h0000;
    clear = 1'b1; req = 4'b0000; req_data = 64'h0;
    m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_left = 0; m_disp = IDLE_W;

    // Reset values
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    chk("rst_gnt",   32'(gnt),          32'(4'b0000));
    chk("rst_busy",  32'(busy),         32'(1'b0));
    chk("rst_owner", 32'(owner),        32'(2'd0));
    chk("rst_disp",  32'(display_data), 32'(16'hFFFF));

    // Single one-cycle request, held for the full grant then idle
    data[2] = 16'h0123;
    step(1'b0, 4'b0100);
    chk("single_gnt",  32'(gnt),          32'(4'b0100));
    chk("single_disp", 32'(display_data), 32'(16'h0123));
    repeat (3) step(1'b0, 4'b0000);
    chk("single_last_gnt", 32'(gnt), 32'(4'b0100));
    step(1'b0, 4'b0000);
    chk("single_rel_gnt",  32'(gnt),          32'(4'b0000));
    chk("single_rel_disp", 32'(display_data), 32'(16'hFFFF));

    // All requesting: owners 0,1,2,3,0 with no idle gap
    step(1'b1, 4'b0000);
    for (int i = 0; i < NREQ; i++) data[i] = 16'(16'h1111 * (i + 1));
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 4'b1111);
      chk("rr_busy", 32'(busy), 32'(1'b1));
      if (c % 4 == 0) begin
        chk("rr_owner", 32'(owner),        32'((c / 4) % NREQ));
        chk("rr_disp",  32'(display_data), 32'(16'h1111 * (((c / 4) % NREQ) + 1)));
      end
    end

    // Late request wins over the still-requesting owner, then owner returns
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0100);
    chk("late_first", 32'(owner), 32'(2'd2));
    repeat (3) step(1'b0, 4'b0110);
    chk("late_hold", 32'(owner), 32'(2'd2));
    step(1'b0, 4'b0110);
    chk("late_win", 32'(owner), 32'(2'd1));
    repeat (4) step(1'b0, 4'b0110);
    chk("late_back", 32'(owner), 32'(2'd2));

    // Live update then freeze after owner drops its request
    step(1'b1, 4'b0000);
    data[0] = 16'h0001;
    step(1'b0, 4'b0001);
    chk("live_1", 32'(display_data), 32'(16'h0001));
    data[0] = 16'h0002;
    step(1'b0, 4'b0001);
    chk("live_2", 32'(display_data), 32'(16'h0002));
    data[0] = 16'h0003;
    step(1'b0, 4'b0000);
    chk("freeze_a", 32'(display_data), 32'(16'h0002));
    data[0] = 16'h0004;
    step(1'b0, 4'b0000);
    chk("freeze_b", 32'(display_data), 32'(16'h0002));
    chk("freeze_gnt", 32'(gnt), 32'(4'b0001));
    step(1'b0, 4'b0000);
    chk("freeze_idle", 32'(display_data), 32'(16'hFFFF));

    // Reset in the middle of a grant
    step(1'b1, 4'b0000);
    data[2] = 16'h0ABC;
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    step(1'b1, 4'b0100);
    chk("mid_rst_gnt",   32'(gnt),          32'(4'b0000));
    chk("mid_rst_busy",  32'(busy),         32'(1'b0));
    chk("mid_rst_owner", 32'(owner),        32'(2'd0));
    chk("mid_rst_disp",  32'(display_data), 32'(16'hFFFF));
    step(1'b0, 4'b1001);
    chk("post_rst_owner", 32'(owner), 32'(2'd0));
    chk("post_rst_gnt",   32'(gnt),   32'(4'b0001));

    // Randomized traffic with occasional reset
    rq = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1) data[i] = 16'($urandom);
      end
      step(($urandom_range(0, 63) == 0), rq);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
